// File: rtl/serial_add_pkg.sv
// Shared constants and state type for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StAdd  = ST_ADD,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell shared by the serial controller; purely combinational.
module serial_adder_ctrl_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per clock, LSB first,
// through a single shared full adder cell, with a one-cycle done pulse on completion.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             cell_sum, cell_carry;

  serial_adder_ctrl_full_adder u_cell (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .cin   (carry_q),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        res_sh_d = {cell_sum, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = cell_carry;
        cnt_d    = cnt_q + 1'b1;
        // Last slice: publish the fully assembled word on the same edge.
        if (cnt_q == CntLast) begin
          state_d = StDone;
          sum_d   = {cell_sum, res_sh_q[WIDTH-1:1]};
          cout_d  = cell_carry;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=3 against an arithmetic model.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start3, cin3, busy3, done3, cout3;
  logic [2:0] a3, b3, sum3;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(3)) dut3 (
    .clk   (clk),
    .rst   (rst),
    .start (start3),
    .a     (a3),
    .b     (b3),
    .cin   (cin3),
    .busy  (busy3),
    .done  (done3),
    .sum   (sum3),
    .cout  (cout3)
  );

  typedef struct {
    int unsigned sum;
    bit          cout;
    int          due;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];

  int checks   = 0;
  int failures = 0;
  int edge_no  = -1;

  // Model view of each instance (0: WIDTH=8, 1: WIDTH=3).
  int          free_at  [2];
  int          k_acc    [2];
  bit          active   [2];
  bit          pend_v   [2];
  int          pend_due [2];
  int unsigned pend_sum [2];
  bit          pend_cout[2];
  int unsigned held_sum [2];
  bit          held_cout[2];

  task automatic model_edge(input int id, input int w, input bit st,
                            input int unsigned av, input int unsigned bv, input bit c);
    longint unsigned tot;
    exp_t e;
    if (rst) begin
      free_at[id]   = edge_no + 1;
      active[id]    = 1'b0;
      pend_v[id]    = 1'b0;
      held_sum[id]  = 0;
      held_cout[id] = 1'b0;
      if (id == 0) q8.delete(); else q3.delete();
      return;
    end
    if (pend_v[id] && pend_due[id] == edge_no) begin
      held_sum[id]  = pend_sum[id];
      held_cout[id] = pend_cout[id];
      pend_v[id]    = 1'b0;
    end
    if (st && edge_no >= free_at[id]) begin
      tot           = longint'(av) + longint'(bv) + longint'(c);
      k_acc[id]     = edge_no;
      active[id]    = 1'b1;
      free_at[id]   = edge_no + w + 2;
      e.sum         = int'(tot & ((64'd1 << w) - 64'd1));
      e.cout        = ((tot >> w) & 64'd1) != 0;
      e.due         = edge_no + w;
      pend_v[id]    = 1'b1;
      pend_due[id]  = e.due;
      pend_sum[id]  = e.sum;
      pend_cout[id] = e.cout;
      if (id == 0) q8.push_back(e); else q3.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    edge_no = edge_no + 1;
    model_edge(0, 8, start8, 32'(a8), 32'(b8), cin8);
    model_edge(1, 3, start3, 32'(a3), 32'(b3), cin3);
  end

  task automatic check_out(input int id, input int w, input bit d, input bit bz,
                           input int unsigned s, input bit co);
    bit   exp_busy;
    bit   have;
    exp_t e;
    exp_busy = active[id] && edge_no >= k_acc[id] && edge_no <= k_acc[id] + w;
    checks++;
    if (bz !== exp_busy) begin
      failures++;
      $display("FAIL busy w%0d edge %0d: got %0b want %0b", w, edge_no, bz, exp_busy);
    end
    have = (id == 0) ? (q8.size() != 0) : (q3.size() != 0);
    if (have) e = (id == 0) ? q8[0] : q3[0];
    if (d) begin
      checks++;
      if (!have) begin
        failures++;
        $display("FAIL spurious_done w%0d edge %0d: got done=1 want done=0", w, edge_no);
      end else begin
        if (id == 0) void'(q8.pop_front()); else void'(q3.pop_front());
        if (s != e.sum || co != e.cout || e.due != edge_no) begin
          failures++;
          $display("FAIL result w%0d edge %0d: got cout=%0b sum=%0h want cout=%0b sum=%0h at edge %0d",
                   w, edge_no, co, s, e.cout, e.sum, e.due);
        end
      end
    end else if (have && e.due <= edge_no) begin
      checks++;
      failures++;
      $display("FAIL missing_done w%0d edge %0d: got done=0 want done=1 (sum=%0h)",
               w, edge_no, e.sum);
      if (id == 0) void'(q8.pop_front()); else void'(q3.pop_front());
    end
    checks++;
    if (s != held_sum[id] || co != held_cout[id]) begin
      failures++;
      $display("FAIL held w%0d edge %0d: got cout=%0b sum=%0h want cout=%0b sum=%0h",
               w, edge_no, co, s, held_cout[id], held_sum[id]);
    end
  endtask

  always @(negedge clk) begin
    if (edge_no >= 0) begin
      check_out(0, 8, done8, busy8, 32'(sum8), cout8);
      check_out(1, 3, done3, busy3, 32'(sum3), cout3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go8(input logic [7:0] av, input logic [7:0] bv, input logic c);
    a8 = av; b8 = bv; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    go8(8'h00, 8'h00, 1'b0);
    repeat (11) tick();
    go8(8'hFF, 8'h01, 1'b0);
    repeat (10) tick();
    go8(8'h7F, 8'h80, 1'b0);
    repeat (10) tick();

    go8(8'hA5, 8'h5A, 1'b1);
    repeat (10) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'($urandom);
      tick();
    end
    start8 = 1'b0;
    repeat (3) tick();

    // Held start: one accepted operation per WIDTH+2 cycles.
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    repeat (40) tick();
    start8 = 1'b0;
    repeat (12) tick();

    // Reset in the middle of an addition.
    go8(8'hC3, 8'h3C, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    go8(8'h10, 8'h20, 1'b0);
    repeat (11) tick();

    // Reset and start together: reset wins.
    rst = 1'b1;
    go8(8'h11, 8'h22, 1'b0);
    rst = 1'b0;
    repeat (3) tick();

    repeat (150) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      start8 = ($urandom_range(0, 3) == 0);
      tick();
    end
    start8 = 1'b0;
    repeat (12) tick();

    for (int ai = 0; ai < 8; ai++) begin
      for (int bi = 0; bi < 8; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a3 = 3'(ai); b3 = 3'(bi); cin3 = 1'(ci); start3 = 1'b1;
          tick();
          start3 = 1'b0;
          repeat (4) begin
            a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom);
            tick();
          end
        end
      end
    end
    repeat (8) tick();

    checks++;
    if (q8.size() != 0 || q3.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d outstanding want 0/0", q8.size(), q3.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
